// File: rtl/ex_issue_ctrl_if.sv
// Decode-to-execute issue handshake plus unit enables and writeback strobe.
// master = decode side / device responder, slave = issue controller.
interface ex_issue_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_unit;
    logic       in_wb;
    logic [7:0] in_rd;
    logic       alu_en;
    logic       fpu_en;
    logic       bu_en;
    logic       dev_en;
    logic       dev_done;
    logic       wb_valid;
    logic [7:0] wb_rd;
    logic       busy;
    logic       dev_err;

    modport master (
        output in_valid, in_unit, in_wb, in_rd, dev_done,
        input  in_ready, alu_en, fpu_en, bu_en, dev_en, wb_valid, wb_rd, busy, dev_err
    );

    modport slave (
        input  in_valid, in_unit, in_wb, in_rd, dev_done,
        output in_ready, alu_en, fpu_en, bu_en, dev_en, wb_valid, wb_rd, busy, dev_err
    );
endinterface

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: routes one op per handshake to ALU/FPU/BU/DEV,
// stalls issue for multi-cycle units and emits a registered writeback strobe.
module ex_issue_ctrl #(
    parameter int unsigned FPU_LAT     = 3,
    parameter int unsigned DEV_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rstn,
    ex_issue_ctrl_if.slave     bus
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned RD_W   = 8;
    localparam int unsigned UNIT_W = 2;

    localparam logic [UNIT_W-1:0] UNIT_ALU = UNIT_W'(0);
    localparam logic [UNIT_W-1:0] UNIT_FPU = UNIT_W'(1);
    localparam logic [UNIT_W-1:0] UNIT_BU  = UNIT_W'(2);
    localparam logic [UNIT_W-1:0] UNIT_DEV = UNIT_W'(3);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FPU_WAIT = 2'd1,
        S_DEV_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RD_W-1:0]   op_rd_q, op_rd_d;
    logic              op_wb_q, op_wb_d;
    logic              pend_wb_q, pend_wb_d;
    logic              in_ready_q, in_ready_d;
    logic              alu_en_q, alu_en_d;
    logic              fpu_en_q, fpu_en_d;
    logic              bu_en_q, bu_en_d;
    logic              dev_en_q, dev_en_d;
    logic              wb_valid_q, wb_valid_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic              busy_q, busy_d;
    logic              dev_err_q, dev_err_d;
    logic              accept;

    // Next-state and next-output logic; every output is the register of its _d value.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_rd_d    = op_rd_q;
        op_wb_d    = op_wb_q;
        pend_wb_d  = 1'b0;
        alu_en_d   = 1'b0;
        fpu_en_d   = 1'b0;
        bu_en_d    = 1'b0;
        dev_en_d   = dev_en_q;
        dev_err_d  = dev_err_q;
        wb_valid_d = pend_wb_q;
        wb_rd_d    = pend_wb_q ? op_rd_q : wb_rd_q;
        accept     = bus.in_valid && in_ready_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_rd_d = bus.in_rd;
                    op_wb_d = bus.in_wb;
                    unique case (bus.in_unit)
                        UNIT_ALU: begin
                            alu_en_d  = 1'b1;
                            pend_wb_d = bus.in_wb;
                        end
                        UNIT_BU: begin
                            bu_en_d   = 1'b1;
                            pend_wb_d = bus.in_wb;
                        end
                        UNIT_FPU: begin
                            fpu_en_d = 1'b1;
                            state_d  = S_FPU_WAIT;
                            cnt_d    = CNT_W'(FPU_LAT);
                        end
                        UNIT_DEV: begin
                            dev_en_d = 1'b1;
                            state_d  = S_DEV_WAIT;
                            cnt_d    = CNT_W'(1);
                        end
                        default: ;
                    endcase
                end
            end
            S_FPU_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = S_IDLE;
                    wb_valid_d = op_wb_q;
                    wb_rd_d    = op_rd_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DEV_WAIT: begin
                // cnt_q is the number of dev_en cycles seen so far, including this one.
                if (bus.dev_done) begin
                    dev_en_d   = 1'b0;
                    state_d    = S_IDLE;
                    wb_valid_d = op_wb_q;
                    wb_rd_d    = op_rd_q;
                end else if (cnt_q == CNT_W'(DEV_TIMEOUT)) begin
                    dev_en_d  = 1'b0;
                    state_d   = S_IDLE;
                    dev_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                dev_en_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == S_IDLE) && !dev_err_d;
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any outstanding op.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_rd_q    <= '0;
            op_wb_q    <= 1'b0;
            pend_wb_q  <= 1'b0;
            in_ready_q <= 1'b1;
            alu_en_q   <= 1'b0;
            fpu_en_q   <= 1'b0;
            bu_en_q    <= 1'b0;
            dev_en_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            busy_q     <= 1'b0;
            dev_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_rd_q    <= op_rd_d;
            op_wb_q    <= op_wb_d;
            pend_wb_q  <= pend_wb_d;
            in_ready_q <= in_ready_d;
            alu_en_q   <= alu_en_d;
            fpu_en_q   <= fpu_en_d;
            bu_en_q    <= bu_en_d;
            dev_en_q   <= dev_en_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            busy_q     <= busy_d;
            dev_err_q  <= dev_err_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.alu_en   = alu_en_q;
    assign bus.fpu_en   = fpu_en_q;
    assign bus.bu_en    = bu_en_q;
    assign bus.dev_en   = dev_en_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.busy     = busy_q;
    assign bus.dev_err  = dev_err_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl with FPU_LAT=3, DEV_TIMEOUT=8.
module tb_ex_issue_ctrl;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    ex_issue_ctrl_if bus();

    ex_issue_ctrl #(.FPU_LAT(3), .DEV_TIMEOUT(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] unit, input logic wb, input logic [7:0] rd);
        bus.in_valid = v;
        bus.in_unit  = unit;
        bus.in_wb    = wb;
        bus.in_rd    = rd;
    endtask

    initial begin
        drive(1'b0, 2'd0, 1'b0, 8'd0);
        bus.dev_done = 1'b0;

        // Reset values
        tick(); tick();
        chk("rst_alu_en",   32'(bus.alu_en),   32'd0);
        chk("rst_dev_en",   32'(bus.dev_en),   32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_rd",    32'(bus.wb_rd),    32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_dev_err",  32'(bus.dev_err),  32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rstn = 1'b1;
        tick();

        // Four back-to-back ALU ops, wb stream lags by two cycles
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'd0, 1'b1, 8'(i));
            tick();
            chk("alu_en", 32'(bus.alu_en), 32'd1);
            if (i == 1) chk("alu_wb_idle", 32'(bus.wb_valid), 32'd0);
            else begin
                chk("alu_wb_valid", 32'(bus.wb_valid), 32'd1);
                chk("alu_wb_rd",    32'(bus.wb_rd),    32'(i - 1));
            end
        end
        drive(1'b0, 2'd0, 1'b0, 8'd0);
        tick();
        chk("alu_en_end",    32'(bus.alu_en),   32'd0);
        chk("alu_wb_last",   32'(bus.wb_valid), 32'd1);
        chk("alu_wb_rd4",    32'(bus.wb_rd),    32'd4);
        tick();
        chk("alu_wb_drop",   32'(bus.wb_valid), 32'd0);

        // FPU rd7 then ALU rd8 held pending while FPU busy
        drive(1'b1, 2'd1, 1'b1, 8'd7);
        tick();
        chk("fpu_en",        32'(bus.fpu_en),   32'd1);
        chk("fpu_ready_t1",  32'(bus.in_ready), 32'd0);
        chk("fpu_busy_t1",   32'(bus.busy),     32'd1);
        drive(1'b1, 2'd0, 1'b1, 8'd8);
        tick();
        chk("fpu_en_pulse",  32'(bus.fpu_en),   32'd0);
        chk("fpu_ready_t2",  32'(bus.in_ready), 32'd0);
        chk("fpu_alu_hold2", 32'(bus.alu_en),   32'd0);
        tick();
        chk("fpu_ready_t3",  32'(bus.in_ready), 32'd0);
        chk("fpu_wb_early",  32'(bus.wb_valid), 32'd0);
        chk("fpu_alu_hold3", 32'(bus.alu_en),   32'd0);
        tick();
        chk("fpu_wb_valid",  32'(bus.wb_valid), 32'd1);
        chk("fpu_wb_rd",     32'(bus.wb_rd),    32'd7);
        chk("fpu_ready_t4",  32'(bus.in_ready), 32'd1);
        chk("fpu_busy_t4",   32'(bus.busy),     32'd0);
        chk("fpu_alu_hold4", 32'(bus.alu_en),   32'd0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 8'd0);
        chk("fa_alu_en",     32'(bus.alu_en),   32'd1);
        chk("fa_wb_gap",     32'(bus.wb_valid), 32'd0);
        tick();
        chk("fa_wb_valid",   32'(bus.wb_valid), 32'd1);
        chk("fa_wb_rd",      32'(bus.wb_rd),    32'd8);

        // BU without writeback, then dev_done while idle is ignored
        drive(1'b1, 2'd2, 1'b0, 8'd11);
        tick();
        drive(1'b0, 2'd0, 1'b0, 8'd0);
        bus.dev_done = 1'b1;
        chk("bu_en",         32'(bus.bu_en),    32'd1);
        tick();
        bus.dev_done = 1'b0;
        chk("bu_no_wb",      32'(bus.wb_valid), 32'd0);
        chk("idle_done_en",  32'(bus.dev_en),   32'd0);
        tick();
        chk("idle_done_wb",  32'(bus.wb_valid), 32'd0);
        chk("idle_done_bsy", 32'(bus.busy),     32'd0);

        // DEV rd5, dev_done in 6th dev_en cycle
        drive(1'b1, 2'd3, 1'b1, 8'd5);
        tick();
        drive(1'b0, 2'd0, 1'b0, 8'd0);
        for (int k = 1; k <= 6; k++) begin
            chk("dev_en_hold",   32'(bus.dev_en),   32'd1);
            chk("dev_wb_hold",   32'(bus.wb_valid), 32'd0);
            if (k == 6) bus.dev_done = 1'b1;
            tick();
        end
        bus.dev_done = 1'b0;
        chk("dev_en_drop",   32'(bus.dev_en),   32'd0);
        chk("dev_wb_valid",  32'(bus.wb_valid), 32'd1);
        chk("dev_wb_rd",     32'(bus.wb_rd),    32'd5);
        chk("dev_ready",     32'(bus.in_ready), 32'd1);
        tick();
        chk("dev_wb_drop",   32'(bus.wb_valid), 32'd0);

        // DEV rd9 done in its first cycle, ALU rd10 accepted in the wb cycle
        drive(1'b1, 2'd3, 1'b1, 8'd9);
        tick();
        drive(1'b0, 2'd0, 1'b0, 8'd0);
        bus.dev_done = 1'b1;
        chk("dev1_en",       32'(bus.dev_en),   32'd1);
        tick();
        bus.dev_done = 1'b0;
        chk("dev1_en_drop",  32'(bus.dev_en),   32'd0);
        chk("dev1_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("dev1_wb_rd",    32'(bus.wb_rd),    32'd9);
        chk("dev1_ready",    32'(bus.in_ready), 32'd1);
        drive(1'b1, 2'd0, 1'b1, 8'd10);
        tick();
        drive(1'b0, 2'd0, 1'b0, 8'd0);
        chk("dev1_alu_en",   32'(bus.alu_en),   32'd1);
        tick();
        chk("dev1_alu_wb",   32'(bus.wb_valid), 32'd1);
        chk("dev1_alu_rd",   32'(bus.wb_rd),    32'd10);

        // DEV timeout after 8 cycles: sticky error, no wb, issue frozen
        drive(1'b1, 2'd3, 1'b1, 8'd6);
        tick();
        drive(1'b0, 2'd0, 1'b0, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            chk("to_en_hold",  32'(bus.dev_en),  32'd1);
            chk("to_err_low",  32'(bus.dev_err), 32'd0);
            tick();
        end
        chk("to_en_drop",    32'(bus.dev_en),   32'd0);
        chk("to_err",        32'(bus.dev_err),  32'd1);
        chk("to_no_wb",      32'(bus.wb_valid), 32'd0);
        chk("to_ready",      32'(bus.in_ready), 32'd0);
        chk("to_busy",       32'(bus.busy),     32'd0);
        drive(1'b1, 2'd0, 1'b1, 8'd14);
        tick();
        chk("to_frozen_alu", 32'(bus.alu_en),   32'd0);
        tick();
        chk("to_frozen_rdy", 32'(bus.in_ready), 32'd0);
        chk("to_err_sticky", 32'(bus.dev_err),  32'd1);
        drive(1'b0, 2'd0, 1'b0, 8'd0);

        // Reset clears error; then reset asserted mid FPU_WAIT
        rstn = 1'b0;
        #2;
        chk("rst_err_clr",   32'(bus.dev_err),  32'd0);
        chk("rst_ready",     32'(bus.in_ready), 32'd1);
        tick();
        rstn = 1'b1;
        tick();
        drive(1'b1, 2'd1, 1'b1, 8'd12);
        tick();
        drive(1'b0, 2'd0, 1'b0, 8'd0);
        chk("rf_fpu_en",     32'(bus.fpu_en),   32'd1);
        tick();
        chk("rf_busy",       32'(bus.busy),     32'd1);
        rstn = 1'b0;
        #2;
        chk("rf_async_busy", 32'(bus.busy),     32'd0);
        chk("rf_async_fpu",  32'(bus.fpu_en),   32'd0);
        chk("rf_async_wb",   32'(bus.wb_valid), 32'd0);
        tick(); tick();
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rf_no_wb",    32'(bus.wb_valid), 32'd0);
        end
        drive(1'b1, 2'd0, 1'b1, 8'd13);
        tick();
        drive(1'b0, 2'd0, 1'b0, 8'd0);
        chk("rf_alu_en",     32'(bus.alu_en),   32'd1);
        tick();
        chk("rf_alu_wb",     32'(bus.wb_valid), 32'd1);
        chk("rf_alu_rd",     32'(bus.wb_rd),    32'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
